// File: rtl/storage_arbiter_pkg.sv
// storage_arbiter_pkg: shared constants and state encodings for the storage arbiter
// Contents: requester indices, arbiter FSM states, default bus widths.
package storage_arbiter_pkg;
    localparam int REQ_INPUT  = 0;
    localparam int REQ_CALC   = 1;
    localparam int REQ_DISP   = 2;
    localparam int NUM_REQ    = 3;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;
    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN, ARB_BLOCK} arb_state_t;
endpackage

// File: rtl/storage_arbiter_if.sv
// storage_arbiter_if: requester and storage bus bundle around the storage arbiter
// Signals: req/we/addr/wdata (per requester, packed {disp,calc,input}), gnt/rvalid/rdata/hold_err back to
// requesters, storage_addr/storage_wdata/storage_we/storage_rdata to and from Matrix_storage.
// Modports: master = requesters plus storage side, slave = arbiter.
interface storage_arbiter_if import storage_arbiter_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [NUM_REQ-1:0]        req, we, gnt, rvalid;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [DATA_W-1:0]         rdata, storage_wdata, storage_rdata;
    logic [ADDR_W-1:0]         storage_addr;
    logic                      hold_err, storage_we;
    modport master (
        output req, we, addr, wdata, storage_rdata,
        input  gnt, rvalid, rdata, hold_err, storage_addr, storage_wdata, storage_we
    );
    modport slave (
        input  req, we, addr, wdata, storage_rdata,
        output gnt, rvalid, rdata, hold_err, storage_addr, storage_wdata, storage_we
    );
endinterface

// File: rtl/storage_arbiter_picker.sv
// storage_arbiter_picker: combinational one-hot winner select among eligible requests
// Ports: req (eligible requests), ptr (last owner, round-robin build only), pick (one-hot winner or 0).
// STORAGE_ARB_RR_EN defined: round-robin starting after ptr; undefined: fixed calc > input > display.
module storage_arbiter_picker import storage_arbiter_pkg::*; (
    input  logic [NUM_REQ-1:0] req,
`ifdef STORAGE_ARB_RR_EN
    input  logic [1:0]         ptr,
`endif
    output logic [NUM_REQ-1:0] pick
);
`ifdef STORAGE_ARB_RR_EN
    logic [1:0] j;
    // Walk from the lowest priority slot up so the slot right after ptr wins last.
    always_comb begin
        pick = '0;
        j = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = 2'((int'(ptr) + k) % NUM_REQ);
            if (req[j]) pick = NUM_REQ'(1) << j;
        end
    end
`else
    assign pick = req[REQ_CALC]  ? NUM_REQ'(1) << REQ_CALC  :
                  req[REQ_INPUT] ? NUM_REQ'(1) << REQ_INPUT :
                  req[REQ_DISP]  ? NUM_REQ'(1) << REQ_DISP  : '0;
`endif
endmodule

// File: rtl/storage_arbiter.sv
// storage_arbiter: req/gnt arbiter for single-port Matrix_storage with ownership lock, read-valid and hold watchdog
// Ports: clk, sys_rst (async, active-high), bus (storage_arbiter_if.slave: requester and storage signals).
// Parameters: ADDR_W, DATA_W, MAX_HOLD (max consecutive grant cycles, 0 disables watchdog).
// Build option: STORAGE_ARB_RR_EN selects round-robin instead of fixed priority.
module storage_arbiter import storage_arbiter_pkg::*; #(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = 4096
) (
    input logic clk,
    input logic sys_rst,
    storage_arbiter_if.slave bus
);
    localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
    arb_state_t         state;
    logic [NUM_REQ-1:0] gnt, blk, rvalid, pick;
    logic [HW-1:0]      hold_cnt;
    logic               hold_err, swe;
`ifdef STORAGE_ARB_RR_EN
    logic [1:0]         rr_ptr;
    storage_arbiter_picker u_picker (.req(bus.req & ~blk), .ptr(rr_ptr), .pick(pick));
`else
    storage_arbiter_picker u_picker (.req(bus.req & ~blk), .pick(pick));
`endif
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= ARB_IDLE;
            gnt      <= '0;
            blk      <= '0;
            rvalid   <= '0;
            hold_err <= 1'b0;
            hold_cnt <= '0;
`ifdef STORAGE_ARB_RR_EN
            rr_ptr   <= '0;
`endif
        end else begin
            rvalid   <= gnt & bus.req & ~bus.we;
            hold_err <= 1'b0;
            // A revoked requester stays masked until it lowers its request.
            blk      <= blk & bus.req;
            if (state == ARB_OWN) begin
                if (!(|(gnt & bus.req))) begin
                    gnt   <= '0;
                    state <= ARB_IDLE;
                end else if (MAX_HOLD != 0 && hold_cnt == HW'(MAX_HOLD - 1)) begin
                    gnt      <= '0;
                    blk      <= gnt;
                    hold_err <= 1'b1;
                    state    <= ARB_BLOCK;
                end else if (hold_cnt != '1) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end else if (|pick) begin
                gnt      <= pick;
                hold_cnt <= '0;
                state    <= ARB_OWN;
`ifdef STORAGE_ARB_RR_EN
                rr_ptr   <= {pick[REQ_DISP], pick[REQ_CALC]};
`endif
            end else if (state == ARB_BLOCK && !(|(blk & bus.req))) begin
                state <= ARB_IDLE;
            end
        end
    end
    always_comb begin
        bus.storage_addr  = '0;
        bus.storage_wdata = '0;
        swe = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) begin
                bus.storage_addr  = bus.addr[i*ADDR_W +: ADDR_W];
                bus.storage_wdata = bus.wdata[i*DATA_W +: DATA_W];
                swe = bus.we[i];
            end
    end
    // Write strobe is killed by reset combinationally, not just via the cleared grant.
    assign bus.storage_we = swe & ~sys_rst;
    assign bus.gnt        = gnt;
    assign bus.rvalid     = rvalid;
    assign bus.hold_err   = hold_err;
    assign bus.rdata      = bus.storage_rdata;
endmodule

// File: tb/tb_storage_arbiter.sv
// tb_storage_arbiter: directed self-checking bench for storage_arbiter with a synchronous-read memory model
module tb_storage_arbiter;
    import storage_arbiter_pkg::*;
    logic clk = 1'b0;
    logic sys_rst;
    logic preload;
    int n_checks = 0;
    int n_fails = 0;
    logic [31:0] mem [256];
    logic [31:0] burst_exp [4] = '{32'h0BAD_0000, 32'h1111_2222, 32'h3333_4444, 32'hCAFE_F00D};
    logic [2:0] post_release_gnt;

    storage_arbiter_if bus ();
    storage_arbiter #(.MAX_HOLD(8)) dut (.clk(clk), .sys_rst(sys_rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h00] <= 32'h0BAD_0000;
            mem[8'h01] <= 32'h1111_2222;
            mem[8'h02] <= 32'h3333_4444;
            mem[8'h03] <= 32'hCAFE_F00D;
            mem[8'h05] <= 32'hAAAA_5555;
            mem[8'h10] <= 32'hDEAD_BEEF;
        end else if (bus.storage_we) begin
            mem[bus.storage_addr] <= bus.storage_wdata;
        end
        bus.storage_rdata <= mem[bus.storage_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
        bus.req[i] = r;
        bus.we[i] = w;
        bus.addr[i*8 +: 8] = a;
        bus.wdata[i*32 +: 32] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
`ifdef STORAGE_ARB_RR_EN
        post_release_gnt = 3'b100;
`else
        post_release_gnt = 3'b001;
`endif
        sys_rst = 1'b1;
        preload = 1'b1;
        bus.req = '0;
        bus.we = '0;
        bus.addr = '0;
        bus.wdata = '0;
        tick();
        preload = 1'b0;
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_rvalid", 32'(bus.rvalid), 32'h0);
        check("rst_hold_err", 32'(bus.hold_err), 32'h0);
        check("rst_we", 32'(bus.storage_we), 32'h0);
        tick();
        sys_rst = 1'b0;

        // single read by input
        drive(0, 1, 0, 8'h10, 0);
        tick();
        check("t1_gnt", 32'(bus.gnt), 32'h1);
        check("t1_addr", 32'(bus.storage_addr), 32'h10);
        tick();
        check("t1_rvalid", 32'(bus.rvalid), 32'h1);
        check("t1_rdata", bus.rdata, 32'hDEAD_BEEF);
        drive(0, 0, 0, 8'h10, 0);
        tick();
        check("t1_rvalid_off", 32'(bus.rvalid), 32'h0);
        check("t1_gnt_off", 32'(bus.gnt), 32'h0);

        // simultaneous requests
        drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(2, 1, 0, 0, 0);
        tick();
        check("t2_gnt_first", 32'(bus.gnt), 32'h2);
        drive(1, 0, 0, 0, 0);
        tick();
        check("t2_dead_cycle", 32'(bus.gnt), 32'h0);
        tick();
        check("t2_gnt_next", 32'(bus.gnt), 32'(post_release_gnt));
        drive(0, 0, 0, 0, 0);
        drive(2, 0, 0, 0, 0);
        tick();
        check("t2_gnt_off", 32'(bus.gnt), 32'h0);

        // non-owner write is blocked
        drive(2, 1, 0, 8'h20, 0);
        tick();
        check("t3_gnt_disp", 32'(bus.gnt), 32'h4);
        drive(0, 1, 1, 8'h05, 32'h1234);
        #1;
        check("t3_we_blocked", 32'(bus.storage_we), 32'h0);
        check("t3_addr_owner", 32'(bus.storage_addr), 32'h20);
        tick();
        check("t3_gnt_hold", 32'(bus.gnt), 32'h4);
        check("t3_mem_untouched", mem[8'h05], 32'hAAAA_5555);
        drive(2, 0, 0, 8'h20, 0);
        tick();
        check("t3_dead_cycle", 32'(bus.gnt), 32'h0);
        tick();
        check("t3_gnt_input", 32'(bus.gnt), 32'h1);
        check("t3_we_owner", 32'(bus.storage_we), 32'h1);
        check("t3_wdata", bus.storage_wdata, 32'h1234);
        tick();
        check("t3_mem_written", mem[8'h05], 32'h1234);
        drive(0, 0, 0, 0, 0);
        tick();

        // hold watchdog
        drive(1, 1, 0, 0, 0);
        tick();
        check("t4_gnt_calc", 32'(bus.gnt), 32'h2);
        drive(2, 1, 0, 0, 0);
        for (int k = 2; k <= 8; k++) tick();
        check("t4_gnt_cycle8", 32'(bus.gnt), 32'h2);
        check("t4_no_err_yet", 32'(bus.hold_err), 32'h0);
        tick();
        check("t4_revoked", 32'(bus.gnt), 32'h0);
        check("t4_hold_err", 32'(bus.hold_err), 32'h1);
        tick();
        check("t4_gnt_disp", 32'(bus.gnt), 32'h4);
        check("t4_err_pulse", 32'(bus.hold_err), 32'h0);
        drive(2, 0, 0, 0, 0);
        tick();
        check("t4_disp_release", 32'(bus.gnt), 32'h0);
        for (int k = 0; k < 6; k++) tick();
        check("t4_calc_blocked", 32'(bus.gnt), 32'h0);
        drive(1, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 0, 0);
        tick();
        check("t4_calc_regrant", 32'(bus.gnt), 32'h2);
        drive(1, 0, 0, 0, 0);
        tick();

        // reset during a calc write burst
        drive(1, 1, 1, 8'h30, 32'h55);
        tick();
        check("t5_gnt", 32'(bus.gnt), 32'h2);
        check("t5_we", 32'(bus.storage_we), 32'h1);
        tick();
        check("t5_mem30", mem[8'h30], 32'h55);
        drive(1, 1, 1, 8'h31, 32'h66);
        sys_rst = 1'b1;
        #1;
        check("t5_rst_gnt", 32'(bus.gnt), 32'h0);
        check("t5_rst_we", 32'(bus.storage_we), 32'h0);
        tick();
        check("t5_mem31", mem[8'h31], 32'h0);
        sys_rst = 1'b0;
        drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(2, 1, 0, 0, 0);
        tick();
        check("t5_first_gnt", 32'(bus.gnt), 32'h2);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(2, 0, 0, 0, 0);
        tick();
        tick();

        // pipelined read burst
        drive(1, 1, 0, 8'h00, 0);
        tick();
        check("t6_gnt", 32'(bus.gnt), 32'h2);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 8'(i), 0);
            tick();
            check($sformatf("t6_rvalid%0d", i), 32'(bus.rvalid), 32'h2);
            check($sformatf("t6_rdata%0d", i), bus.rdata, burst_exp[i]);
        end
        drive(1, 0, 0, 0, 0);
        tick();
        check("t6_rvalid_end", 32'(bus.rvalid), 32'h0);
        check("t6_gnt_end", 32'(bus.gnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
